// File: rtl/time_set_pkg.sv
// Shared types and constants for the MM:SS time-entry controller.
package time_set_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EDIT_MH = 3'd1,
    ST_EDIT_ML = 3'd2,
    ST_EDIT_SH = 3'd3,
    ST_EDIT_SL = 3'd4,
    ST_COMMIT  = 3'd5
  } state_e;

  localparam logic [3:0] MH_MAX = 4'd5;
  localparam logic [3:0] ML_MAX = 4'd9;
  localparam logic [3:0] SH_MAX = 4'd5;
  localparam logic [3:0] SL_MAX = 4'd9;

  localparam int BIT_MH = 3;
  localparam int BIT_ML = 2;
  localparam int BIT_SH = 1;
  localparam int BIT_SL = 0;

  // Wraps to 0 at the limit; an out-of-range value also lands on 0.
  function automatic logic [3:0] digit_inc(input logic [3:0] d, input logic [3:0] max);
    return (d >= max) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [3:0] digit_clamp(input logic [3:0] d, input logic [3:0] max);
    return (d > max) ? 4'd0 : d;
  endfunction

  function automatic logic is_edit(input state_e s);
    return (s == ST_EDIT_MH) || (s == ST_EDIT_ML) || (s == ST_EDIT_SH) || (s == ST_EDIT_SL);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button front end: 2-flop synchroniser, debounce counter, rising-edge press pulse.
// The accepted level is exported only when TIMESET_AUTOREPEAT_EN is defined.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
`ifdef TIMESET_AUTOREPEAT_EN
  ,
  output logic level
`endif
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;
  logic          stable_dly_q, stable_dly_d;
  logic          press_q, press_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      cnt_q        <= '0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      cnt_q        <= cnt_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      press_q      <= press_d;
    end
  end

  // The counter only runs while the synchronised level disagrees with the
  // accepted one, so any bounce back to the old level restarts it from 0.
  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    stable_dly_d = stable_q;
    press_d      = stable_q & ~stable_dly_q;
  end

  assign press = press_q;
`ifdef TIMESET_AUTOREPEAT_EN
  assign level = stable_q;
`endif

endmodule

// File: rtl/time_set_ctrl.sv
// Button-driven MM:SS entry: digit-select FSM, shadow set_* digits, load strobe, blink mask.
// Optional hold-to-repeat increment is enabled by defining TIMESET_AUTOREPEAT_EN.
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BLINK_CYCLES    = 25000000
`ifdef TIMESET_AUTOREPEAT_EN
  ,
  parameter int REPEAT_CYCLES   = 12500000
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [3:0] cur_min_hi,
  input  logic [3:0] cur_min_lo,
  input  logic [3:0] cur_sec_hi,
  input  logic [3:0] cur_sec_lo,
  output logic [3:0] set_min_hi,
  output logic [3:0] set_min_lo,
  output logic [3:0] set_sec_hi,
  output logic [3:0] set_sec_lo,
  output logic       load,
  output logic       editing,
  output logic [3:0] blink_mask
);

  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  logic mode_press, inc_press, inc_fire;

  state_e        state_q, state_d;
  logic [3:0]    mh_q, mh_d, ml_q, ml_d, sh_q, sh_d, sl_q, sl_d;
  logic          editing_q, editing_d;
  logic          load_q, load_d;
  logic          phase_q, phase_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;

`ifdef TIMESET_AUTOREPEAT_EN
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  logic          mode_level, inc_level, rep_fire;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_mode), .press(mode_press), .level(mode_level)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_db (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_inc), .press(inc_press), .level(inc_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rep_cnt_q <= '0;
    else        rep_cnt_q <= rep_cnt_d;
  end

  // Repeat period is measured from the press pulse; a state change, a
  // release, or a held mode button all restart it.
  always_comb begin
    rep_cnt_d = '0;
    rep_fire  = 1'b0;
    if (is_edit(state_q) && inc_level && !mode_level && !inc_press && (state_d == state_q)) begin
      if (rep_cnt_q == RW'(REPEAT_CYCLES - 1)) begin
        rep_fire = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + 1'b1;
      end
    end
  end

  assign inc_fire = (inc_press | rep_fire) & ~mode_press;
`else
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_mode), .press(mode_press)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_db (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_inc), .press(inc_press)
  );

  assign inc_fire = inc_press & ~mode_press;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mh_q        <= 4'd0;
      ml_q        <= 4'd0;
      sh_q        <= 4'd0;
      sl_q        <= 4'd0;
      editing_q   <= 1'b0;
      load_q      <= 1'b0;
      phase_q     <= 1'b0;
      blink_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mh_q        <= mh_d;
      ml_q        <= ml_d;
      sh_q        <= sh_d;
      sl_q        <= sl_d;
      editing_q   <= editing_d;
      load_q      <= load_d;
      phase_q     <= phase_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (mode_press) state_d = ST_EDIT_MH;
      ST_EDIT_MH: if (mode_press) state_d = ST_EDIT_ML;
      ST_EDIT_ML: if (mode_press) state_d = ST_EDIT_SH;
      ST_EDIT_SH: if (mode_press) state_d = ST_EDIT_SL;
      ST_EDIT_SL: if (mode_press) state_d = ST_COMMIT;
      ST_COMMIT:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mh_d        = mh_q;
    ml_d        = ml_q;
    sh_d        = sh_q;
    sl_d        = sl_q;
    phase_d     = phase_q;
    blink_cnt_d = blink_cnt_q;

    if ((state_q == ST_IDLE) && mode_press) begin
      mh_d = digit_clamp(cur_min_hi, MH_MAX);
      ml_d = digit_clamp(cur_min_lo, ML_MAX);
      sh_d = digit_clamp(cur_sec_hi, SH_MAX);
      sl_d = digit_clamp(cur_sec_lo, SL_MAX);
    end else if (inc_fire) begin
      case (state_q)
        ST_EDIT_MH: mh_d = digit_inc(mh_q, MH_MAX);
        ST_EDIT_ML: ml_d = digit_inc(ml_q, ML_MAX);
        ST_EDIT_SH: sh_d = digit_inc(sh_q, SH_MAX);
        ST_EDIT_SL: sl_d = digit_inc(sl_q, SL_MAX);
        default: ;
      endcase
    end

    // Restarting the phase on an increment keeps the fresh value visible.
    if (((state_q == ST_IDLE) && mode_press) || (inc_fire && is_edit(state_q))) begin
      phase_d     = 1'b0;
      blink_cnt_d = '0;
    end else if (is_edit(state_q)) begin
      if (blink_cnt_q == BW'(BLINK_CYCLES - 1)) begin
        phase_d     = ~phase_q;
        blink_cnt_d = '0;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end else begin
      phase_d     = 1'b0;
      blink_cnt_d = '0;
    end

    editing_d = is_edit(state_d);
    load_d    = (state_d == ST_COMMIT);
  end

  always_comb begin
    blink_mask = 4'b0000;
    if (phase_q) begin
      case (state_q)
        ST_EDIT_MH: blink_mask[BIT_MH] = 1'b1;
        ST_EDIT_ML: blink_mask[BIT_ML] = 1'b1;
        ST_EDIT_SH: blink_mask[BIT_SH] = 1'b1;
        ST_EDIT_SL: blink_mask[BIT_SL] = 1'b1;
        default: ;
      endcase
    end
  end

  assign set_min_hi = mh_q;
  assign set_min_lo = ml_q;
  assign set_sec_hi = sh_q;
  assign set_sec_lo = sl_q;
  assign load       = load_q;
  assign editing    = editing_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl: expected load values are queued by the
// stimulus, popped and compared by a monitor on every load strobe.
module tb_time_set_ctrl;

  localparam int DEB = 4;
  localparam int BLK = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [3:0] cur_min_hi = 4'd0, cur_min_lo = 4'd0, cur_sec_hi = 4'd0, cur_sec_lo = 4'd0;
  logic [3:0] set_min_hi, set_min_lo, set_sec_hi, set_sec_lo;
  logic       load, editing;
  logic [3:0] blink_mask;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;
  logic        load_prev = 1'b0;

  time_set_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .BLINK_CYCLES(BLK)
`ifdef TIMESET_AUTOREPEAT_EN
    ,
    .REPEAT_CYCLES(16)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_min_hi(cur_min_hi), .cur_min_lo(cur_min_lo),
    .cur_sec_hi(cur_sec_hi), .cur_sec_lo(cur_sec_lo),
    .set_min_hi(set_min_hi), .set_min_lo(set_min_lo),
    .set_sec_hi(set_sec_hi), .set_sec_lo(set_sec_lo),
    .load(load), .editing(editing), .blink_mask(blink_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && load) begin
      check("load_editing_low", {31'd0, editing}, 32'd0);
      check("load_single_cycle", {31'd0, load_prev}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_load got %0h expected no load", {set_min_hi, set_min_lo, set_sec_hi, set_sec_lo});
      end else begin
        mon_exp = exp_q.pop_front();
        check("load_value", {16'd0, set_min_hi, set_min_lo, set_sec_hi, set_sec_lo}, {16'd0, mon_exp});
      end
    end
    load_prev <= load;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic m, input logic i);
    btn_mode = m;
    btn_inc  = i;
    tick(DEB + 8);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    tick(DEB + 8);
  endtask

  task automatic set_cur(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    cur_min_hi = a; cur_min_lo = b; cur_sec_hi = c; cur_sec_lo = d;
  endtask

  task automatic mask_window(input string name, input logic [3:0] exp);
    logic [3:0] acc;
    acc = 4'b0000;
    repeat (2 * BLK + 4) begin
      @(negedge clk);
      acc = acc | blink_mask;
    end
    check(name, {28'd0, acc}, {28'd0, exp});
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, {16'd0, set_min_hi, set_min_lo, set_sec_hi, set_sec_lo, load, editing, blink_mask},
          32'd0);
  endtask

  initial begin
    int n;
    logic [3:0] ml_exp;

    tick(3);
    check_outputs_zero("reset_outputs");
    rst_n = 1'b1;
    tick(3);
    check_outputs_zero("idle_outputs");

    // Bouncy mode press must yield one pulse: EDIT_MH.
    set_cur(4'd4, 4'd7, 4'd5, 4'd9);
    btn_mode = 1'b1; tick(1);
    btn_mode = 1'b0; tick(1);
    btn_mode = 1'b1; tick(DEB + 8);
    btn_mode = 1'b0; tick(DEB + 8);
    check("glitch_editing", {31'd0, editing}, 32'd1);
    mask_window("glitch_mask_mh", 4'b1000);
    repeat (3) press(1'b0, 1'b1);
    mask_window("inc_mask_mh", 4'b1000);
    exp_q.push_back({4'd1, 4'd7, 4'd5, 4'd9});
    repeat (4) press(1'b1, 1'b0);
    check("load_seen_1", exp_q.size(), 32'd0);
    check("idle_after_commit", {31'd0, editing}, 32'd0);

    // Wrap of SH and SL without carry.
    set_cur(4'd2, 4'd3, 4'd5, 4'd9);
    repeat (3) press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    check("sh_wrap", {28'd0, set_sec_hi}, 32'd0);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    check("sl_wrap", {28'd0, set_sec_lo}, 32'd0);
    check("sl_no_carry", {28'd0, set_sec_hi}, 32'd0);
    exp_q.push_back({4'd2, 4'd3, 4'd0, 4'd0});
    press(1'b1, 1'b0);
    check("load_seen_2", exp_q.size(), 32'd0);

    // Out-of-range digits are captured as 0.
    set_cur(4'd6, 4'd3, 4'd5, 4'd11);
    exp_q.push_back({4'd0, 4'd3, 4'd5, 4'd0});
    repeat (5) press(1'b1, 1'b0);
    check("load_seen_3", exp_q.size(), 32'd0);

    // Simultaneous mode+inc in EDIT_ML: mode wins.
    set_cur(4'd1, 4'd2, 4'd3, 4'd4);
    repeat (2) press(1'b1, 1'b0);
    press(1'b1, 1'b1);
    check("simul_min_lo", {28'd0, set_min_lo}, 32'd2);
    mask_window("simul_mask_sh", 4'b0010);
    exp_q.push_back({4'd1, 4'd2, 4'd3, 4'd4});
    repeat (2) press(1'b1, 1'b0);
    check("load_seen_4", exp_q.size(), 32'd0);

    // Blink cadence in EDIT_ML.
    set_cur(4'd0, 4'd2, 4'd0, 4'd0);
    repeat (2) press(1'b1, 1'b0);
    n = 0;
    while (blink_mask != 4'b0000 && n < 40) begin tick(1); n++; end
    while (blink_mask == 4'b0000 && n < 80) begin tick(1); n++; end
    check("blink_found", {31'd0, n < 80}, 32'd1);
    n = 0;
    while (blink_mask == 4'b0100 && n < 30) begin tick(1); n++; end
    check("blink_on_len", n, BLK);
    n = 0;
    while (blink_mask == 4'b0000 && n < 30) begin tick(1); n++; end
    check("blink_off_len", n, BLK);
    check("blink_on_value", {28'd0, blink_mask}, 32'h4);

    // Held inc: one increment, or three with auto-repeat at 16 cycles.
`ifdef TIMESET_AUTOREPEAT_EN
    ml_exp = 4'd5;
`else
    ml_exp = 4'd3;
`endif
    btn_inc = 1'b1;
    tick(DEB + 3 + 40);
    btn_inc = 1'b0;
    tick(DEB + 8);
    check("hold_inc_min_lo", {28'd0, set_min_lo}, {28'd0, ml_exp});
    exp_q.push_back({4'd0, ml_exp, 4'd0, 4'd0});
    repeat (3) press(1'b1, 1'b0);
    check("load_seen_5", exp_q.size(), 32'd0);

    // Reset while in EDIT_SH.
    set_cur(4'd3, 4'd4, 4'd2, 4'd8);
    repeat (3) press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    check("pre_reset_sec_hi", {28'd0, set_sec_hi}, 32'd3);
    check("pre_reset_editing", {31'd0, editing}, 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_outputs_zero("async_reset_outputs");
    tick(3);
    rst_n = 1'b1;
    tick(5);
    check_outputs_zero("post_reset_outputs");
    press(1'b0, 1'b1);
    check("idle_inc_ignored", {12'd0, set_min_hi, set_min_lo, set_sec_hi, set_sec_lo, editing}, 32'd0);
    press(1'b1, 1'b0);
    check("post_reset_enter", {31'd0, editing}, 32'd1);
    mask_window("post_reset_mask_mh", 4'b1000);
    exp_q.push_back({4'd3, 4'd4, 4'd2, 4'd8});
    repeat (4) press(1'b1, 1'b0);
    check("load_seen_6", exp_q.size(), 32'd0);

    tick(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
Button-driven time-entry controller that writes a new MM:SS value into the running digital clock. It synchronises and debounces two raw push-buttons and walks a digit-select state machine. It presents per-digit BCD values and a one-cycle load strobe to the clock counter, plus a blink mask for the 7-segment decoders.

Parameters:
DEBOUNCE_CYCLES, 1000000, cycles a synchronised button must be stable before its level is accepted (20 ms at 50 MHz).
BLINK_CYCLES, 25000000, half-period of the edit-digit blink (0.5 s at 50 MHz).
REPEAT_CYCLES, 12500000, auto-repeat interval while inc is held (used only with the optional feature).

Ports:
clk  input  1  system clock, 50 MHz.
rst_n  input  1  reset, asynchronous, active-low.
btn_mode  input  1  raw mode button, active-high, asynchronous to clk.
btn_inc  input  1  raw increment button, active-high, asynchronous to clk.
cur_min_hi, cur_min_lo, cur_sec_hi, cur_sec_lo  input  4 each  live BCD time from the clock counter.
set_min_hi, set_min_lo, set_sec_hi, set_sec_lo  output  4 each  BCD value to load.
load  output  1  one-cycle strobe; the clock counter copies set_* on this cycle.
editing  output  1  high while any EDIT state is active; the clock counter freezes while high.
blink_mask  output  4  bit3..0 = min_hi, min_lo, sec_hi, sec_lo; 1 = blank that digit this cycle.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. All flops reset on rst_n low.
- Reset values: set_* = 0, load = 0, editing = 0, blink_mask = 0, state = IDLE, debounce counters = 0, blink phase = 0.
- Input path per button:
  - 2-flop synchroniser.
  - Debounce counter: reloads to 0 on any change of the synchronised level. When it reaches DEBOUNCE_CYCLES-1, the stable level is accepted.
  - Press pulse: one-cycle pulse on the accepted 0->1 edge. The total latency from a stable raw press to the pulse is DEBOUNCE_CYCLES+3 cycles.
- FSM states: IDLE, EDIT_MH, EDIT_ML, EDIT_SH, EDIT_SL, COMMIT.
  - IDLE + mode pulse: copy cur_* into set_* (shadow) and go to EDIT_MH. Any digit out of range is captured as 0.
  - EDIT_MH -> EDIT_ML -> EDIT_SH -> EDIT_SL advance on each mode pulse.
  - EDIT_SL + mode pulse -> COMMIT.
  - COMMIT: load = 1 for exactly this cycle, editing = 0; next state is IDLE unconditionally.
  - inc pulse in EDIT_x increments only the selected digit.
  - inc pulse in IDLE or COMMIT is ignored.
- Digit wrap rules: MH and SH wrap 5 -> 0; ML and SL wrap 9 -> 0. Arithmetic is 4-bit and never produces a value above the digit's limit.
- Simultaneous mode and inc pulses in the same cycle: mode wins and inc is dropped.
- editing is high in EDIT_MH..EDIT_SL, registered, and asserted the cycle after the entering mode pulse.
- Blink:
  - A free-running phase toggles every BLINK_CYCLES while editing. The phase resets to 0 on entry to EDIT_MH.
  - blink_mask has only the selected digit's bit set, and only when phase = 1. It is 0 outside edit states.
  - The phase also resets to 0 on each inc pulse, so the new value is visible immediately.
- Reset mid-edit: return to IDLE with no load pulse; set_* return to 0.

Optional Feature:
- Macro: TIMESET_AUTOREPEAT_EN.
- Defined: while the debounced inc level stays high in an EDIT state, the first increment comes from the press pulse. A further increment fires every REPEAT_CYCLES, with the repeat counter cleared on release or on a state change. The mode-priority rule still applies.
- Undefined: exactly one increment per press; the repeat counter and REPEAT_CYCLES logic are absent.

Decomposition:
- Package time_set_pkg holds:
  - the state enum;
  - the digit limits MH_MAX = 5, ML_MAX = 9, SH_MAX = 5, SL_MAX = 9;
  - the blink_mask bit indices.
- Sub-module btn_debounce (synchroniser, debounce counter, press pulse, parameter DEBOUNCE_CYCLES) is instantiated twice.

Test Plan:
- Run with DEBOUNCE_CYCLES = 4 and BLINK_CYCLES = 8.
- Raw btn_mode toggles 3 times within 3 cycles, then stays high: exactly one mode pulse; state IDLE -> EDIT_MH; editing = 1.
- cur = 4:7:5:9, then mode, inc x3, mode x4: set = 1:7:5:9 (MH 4->5->0->1); load high for exactly 1 cycle; editing = 0 in the load cycle.
- In EDIT_SL with set_sec_lo = 9, inc: set_sec_lo = 0 and no carry into sec_hi. In EDIT_SH with 5, inc: 0.
- mode and inc debounced to pulse in the same cycle in EDIT_ML: state -> EDIT_SH and set_min_lo unchanged.
- Assert rst_n low while in EDIT_SH: load never pulses; all outputs 0 asynchronously; state IDLE.
- Blink check in EDIT_ML: blink_mask alternates 4'b0000 / 4'b0100 every 8 cycles. With TIMESET_AUTOREPEAT_EN and REPEAT_CYCLES = 16, holding inc for 40 cycles gives 3 increments.
